// File: rtl/fp_wb_scheduler_if.sv
// Bundle of issue-side hazard signals and writeback request/grant signals
// shared between the FP writeback scheduler and its environment.
interface fp_wb_scheduler_if;
    logic        issue_valid_i;
    logic [4:0]  issue_frd_i;
    logic [4:0]  issue_freg1_i;
    logic [4:0]  issue_freg2_i;
    logic [4:0]  issue_freg3_i;
    logic [2:0]  issue_src_en_i;
    logic        flush_i;
    logic        stall_o;

    logic [2:0]  req_valid_i;
    logic [14:0] req_frd_i;
    logic [95:0] req_data_i;
    logic [2:0]  req_ready_o;

    logic        fregwrite_o;
    logic [4:0]  frd_o;
    logic [31:0] writeback_data_o;
    logic [31:0] busy_o;

    modport slave (
        input  issue_valid_i, issue_frd_i, issue_freg1_i, issue_freg2_i,
               issue_freg3_i, issue_src_en_i, flush_i,
               req_valid_i, req_frd_i, req_data_i,
        output stall_o, req_ready_o, fregwrite_o, frd_o, writeback_data_o, busy_o
    );

    modport master (
        output issue_valid_i, issue_frd_i, issue_freg1_i, issue_freg2_i,
               issue_freg3_i, issue_src_en_i, flush_i,
               req_valid_i, req_frd_i, req_data_i,
        input  stall_o, req_ready_o, fregwrite_o, frd_o, writeback_data_o, busy_o
    );
endinterface

// File: rtl/fp_wb_scheduler.sv
// FP register-file writeback scheduler: round-robin arbiter over three result
// producers, a one-cycle write port register and a busy-bit hazard scoreboard.
module fp_wb_scheduler (
    input  logic             clk_i,
    input  logic             rst_i,
    fp_wb_scheduler_if.slave bus
);

    logic [1:0]  rr_ptr_q,    rr_ptr_d;
    logic [31:0] busy_q,      busy_d;
    logic        fregwrite_q, fregwrite_d;
    logic [4:0]  frd_q,       frd_d;
    logic [31:0] wb_data_q,   wb_data_d;

    logic [2:0]  grant;
    logic        stall;
    logic        src_hazard;
    logic        waw_hazard;
    logic        issue_fire;
    logic [31:0] clr_mask;
    logic [31:0] set_mask;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [2:0] rr_pick(input logic [2:0] valid, input logic [1:0] ptr);
        logic [2:0] rot;
        logic [2:0] sel_rot;
        logic [2:0] result;
        case (ptr)
            2'd1:    rot = {valid[0], valid[2], valid[1]};
            2'd2:    rot = {valid[1], valid[0], valid[2]};
            default: rot = valid;
        endcase
        if (rot[0]) begin
            sel_rot = 3'b001;
        end else if (rot[1]) begin
            sel_rot = 3'b010;
        end else if (rot[2]) begin
            sel_rot = 3'b100;
        end else begin
            sel_rot = 3'b000;
        end
        case (ptr)
            2'd1:    result = {sel_rot[1], sel_rot[0], sel_rot[2]};
            2'd2:    result = {sel_rot[0], sel_rot[2], sel_rot[1]};
            default: result = sel_rot;
        endcase
        return result;
    endfunction

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        grant = 3'b000;
        if (rst_i) begin
            grant = 3'b000;
        end else begin
            grant = rr_pick(bus.req_valid_i, rr_ptr_q);
        end
    end

    // Hazard detection against the registered scoreboard; no bypass from the write port.
    always_comb begin
        src_hazard = (bus.issue_src_en_i[0] & busy_q[bus.issue_freg1_i]) |
                     (bus.issue_src_en_i[1] & busy_q[bus.issue_freg2_i]) |
                     (bus.issue_src_en_i[2] & busy_q[bus.issue_freg3_i]);
        waw_hazard = busy_q[bus.issue_frd_i];
        stall      = 1'b0;
        if (rst_i) begin
            stall = 1'b0;
        end else if (bus.issue_valid_i) begin
            stall = src_hazard | waw_hazard;
        end else begin
            stall = 1'b0;
        end
        issue_fire = bus.issue_valid_i & ~stall & ~bus.flush_i;
    end

    // Write-port mux and round-robin pointer advance.
    always_comb begin
        fregwrite_d = 1'b0;
        frd_d       = frd_q;
        wb_data_d   = wb_data_q;
        rr_ptr_d    = rr_ptr_q;
        case (grant)
            3'b001: begin
                fregwrite_d = 1'b1;
                frd_d       = bus.req_frd_i[4:0];
                wb_data_d   = bus.req_data_i[31:0];
                rr_ptr_d    = 2'd1;
            end
            3'b010: begin
                fregwrite_d = 1'b1;
                frd_d       = bus.req_frd_i[9:5];
                wb_data_d   = bus.req_data_i[63:32];
                rr_ptr_d    = 2'd2;
            end
            3'b100: begin
                fregwrite_d = 1'b1;
                frd_d       = bus.req_frd_i[14:10];
                wb_data_d   = bus.req_data_i[95:64];
                rr_ptr_d    = 2'd0;
            end
            default: begin
                fregwrite_d = 1'b0;
                frd_d       = frd_q;
                wb_data_d   = wb_data_q;
                rr_ptr_d    = rr_ptr_q;
            end
        endcase
    end

    // Scoreboard update: set wins over a same-cycle clear, flush wipes everything.
    always_comb begin
        clr_mask = 32'd0;
        set_mask = 32'd0;
        if (fregwrite_q) begin
            clr_mask = 32'd1 << frd_q;
        end else begin
            clr_mask = 32'd0;
        end
        if (issue_fire) begin
            set_mask = 32'd1 << bus.issue_frd_i;
        end else begin
            set_mask = 32'd0;
        end
        if (bus.flush_i) begin
            busy_d = 32'd0;
        end else begin
            busy_d = (busy_q & ~clr_mask) | set_mask;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= 2'd0;
            busy_q      <= 32'd0;
            fregwrite_q <= 1'b0;
            frd_q       <= 5'd0;
            wb_data_q   <= 32'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            fregwrite_q <= fregwrite_d;
            frd_q       <= frd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign bus.req_ready_o      = grant;
    assign bus.stall_o          = stall;
    assign bus.fregwrite_o      = fregwrite_q;
    assign bus.frd_o            = frd_q;
    assign bus.writeback_data_o = wb_data_q;
    assign bus.busy_o           = busy_q;

endmodule
